// File: rtl/sram_rw_port_arbiter.sv
// Two-port arbiter in front of a single-port data-array SRAM macro.
// Clears the array after reset, then round-robins port 0 / port 1 one access per cycle.
module sram_rw_port_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 256,
  parameter int MASK_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [MASK_W-1:0] req0_wmask,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [MASK_W-1:0] req1_wmask,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              resp0_valid,
  output logic              resp1_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              init_done,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [MASK_W-1:0] sram_wmask,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  typedef enum logic {INIT, RUN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] init_cnt, init_cnt_nxt;
  logic              rr_ptr, rr_ptr_nxt;
  logic              rd0_q, rd1_q;
  logic              gnt0, gnt1;

  always_comb begin
    state_nxt    = state;
    init_cnt_nxt = init_cnt;
    rr_ptr_nxt   = rr_ptr;
    gnt0         = 1'b0;
    gnt1         = 1'b0;
    sram_en      = 1'b0;
    sram_wmode   = 1'b0;
    sram_addr    = '0;
    sram_wmask   = '0;
    sram_wdata   = '0;
    case (state)
      INIT: begin
        sram_en      = 1'b1;
        sram_wmode   = 1'b1;
        sram_addr    = init_cnt;
        sram_wmask   = '1;
        init_cnt_nxt = init_cnt + 1'b1;
        if (init_cnt == '1) state_nxt = RUN;
      end
      RUN: begin
        // No grants while reset is sampled, so nothing issued then can respond.
        if (!reset) begin
          if (req0_valid && req1_valid) begin
            gnt0       = !rr_ptr;
            gnt1       = rr_ptr;
            rr_ptr_nxt = !rr_ptr;
          end else begin
            gnt0 = req0_valid;
            gnt1 = req1_valid;
          end
        end
        if (gnt0) begin
          sram_en    = 1'b1;
          sram_wmode = req0_write;
          sram_addr  = req0_addr;
          sram_wmask = req0_write ? req0_wmask : '0;
          sram_wdata = req0_wdata;
        end else if (gnt1) begin
          sram_en    = 1'b1;
          sram_wmode = req1_write;
          sram_addr  = req1_addr;
          sram_wmask = req1_write ? req1_wmask : '0;
          sram_wdata = req1_wdata;
        end
      end
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= INIT;
      init_cnt <= '0;
      rr_ptr   <= 1'b0;
      rd0_q    <= 1'b0;
      rd1_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      init_cnt <= init_cnt_nxt;
      rr_ptr   <= rr_ptr_nxt;
      rd0_q    <= gnt0 && !req0_write;
      rd1_q    <= gnt1 && !req1_write;
    end
  end

  assign req0_ready  = gnt0;
  assign req1_ready  = gnt1;
  // A reset in the response cycle drops the in-flight read.
  assign resp0_valid = rd0_q && !reset;
  assign resp1_valid = rd1_q && !reset;
  assign resp_rdata  = sram_rdata;
  assign init_done   = (state == RUN);

endmodule
